// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, sizing helper.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_if.sv
// EX-stage request bus into the multiply/divide unit and its HI/LO/busy results.
interface md_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);

endinterface

// File: rtl/md_div.sv
// Combinational 32-bit signed/unsigned divider; quotient truncates toward zero,
// remainder follows the dividend's sign. A zero divisor yields don't-care results.
module md_div (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_signed,
  output logic [31:0] o_q,
  output logic [31:0] o_r
);

  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_div_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;

  assign w_neg_a = i_signed & i_a[31];
  assign w_neg_b = i_signed & i_b[31];
  assign w_mag_a = w_neg_a ? (32'd0 - i_a) : i_a;
  assign w_mag_b = w_neg_b ? (32'd0 - i_b) : i_b;
  // Keep the divider well-defined on b=0; the caller discards that result.
  assign w_div_b = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
  assign w_uq    = w_mag_a / w_div_b;
  assign w_ur    = w_mag_a % w_div_b;
  assign o_q     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
  assign o_r     = w_neg_a ? (32'd0 - w_ur) : w_ur;

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: result committed after MULT_CYCLES/DIV_CYCLES busy cycles,
// MTHI/MTLO in one edge; starts while busy are dropped. Divider present only with MDU_DIV_EN.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

  md_state_e          r_state;
  md_state_e          w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic [31:0]        r_res_hi;
  logic [31:0]        r_res_lo;
  logic               r_upd;
  logic               w_long;
  logic               w_accept;
  logic               w_done;
  logic [63:0]        w_ax;
  logic [63:0]        w_bx;
  logic [63:0]        w_prod;

`ifdef MDU_DIV_EN
  logic               w_is_div;
  logic [31:0]        w_q;
  logic [31:0]        w_r;

  md_div u_div (
    .i_a      (bus.a),
    .i_b      (bus.b),
    .i_signed (bus.op == MD_DIV),
    .o_q      (w_q),
    .o_r      (w_r)
  );
`endif

  always_comb begin
    w_long = 1'b0;
`ifdef MDU_DIV_EN
    w_is_div = 1'b0;
`endif
    case (bus.op)
      MD_MULT, MD_MULTU: w_long = 1'b1;
`ifdef MDU_DIV_EN
      MD_DIV, MD_DIVU: begin
        w_long   = 1'b1;
        w_is_div = 1'b1;
      end
`endif
      default: w_long = 1'b0;
    endcase
  end

  assign w_accept = (r_state == ST_IDLE) && bus.start && w_long;
  assign w_done   = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1));

  // Low 64 bits of the 64x64 product are the correct two's-complement result when sign-extended.
  assign w_ax   = (bus.op == MD_MULT) ? {{32{bus.a[31]}}, bus.a} : {32'd0, bus.a};
  assign w_bx   = (bus.op == MD_MULT) ? {{32{bus.b[31]}}, bus.b} : {32'd0, bus.b};
  assign w_prod = w_ax * w_bx;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_BUSY;
      ST_BUSY: if (w_done)   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == ST_BUSY);
  end

  assign bus.hi = r_hi;
  assign bus.lo = r_lo;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_upd    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
`ifdef MDU_DIV_EN
        if (w_is_div) begin
          r_cnt    <= CNT_W'(DIV_CYCLES);
          r_res_hi <= w_r;
          r_res_lo <= w_q;
          r_upd    <= (bus.b != 32'd0);
        end else
`endif
        begin
          r_cnt    <= CNT_W'(MULT_CYCLES);
          r_res_hi <= w_prod[63:32];
          r_res_lo <= w_prod[31:0];
          r_upd    <= 1'b1;
        end
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_done && r_upd) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end else if ((r_state == ST_IDLE) && bus.start) begin
        if (bus.op == MD_MTHI) r_hi <= bus.a;
        if (bus.op == MD_MTLO) r_lo <= bus.a;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed plus randomized checks of md_unit against an arithmetic HI/LO model.
module tb_md_unit;
  import md_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_if bus ();

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: busy length and final HI/LO from the architectural rules.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n, output logic [31:0] nh, output logic [31:0] nl);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    n  = 0;
    nh = m_hi;
    nl = m_lo;
    case (op)
      MD_MULT: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        n  = MULT_N;
        nh = p[63:32];
        nl = p[31:0];
      end
      MD_MULTU: begin
        p  = {32'd0, a} * {32'd0, b};
        n  = MULT_N;
        nh = p[63:32];
        nl = p[31:0];
      end
`ifdef MDU_DIV_EN
      MD_DIV: begin
        n = DIV_N;
        if (b != 32'd0) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          sq = sa / sb;
          sr = sa % sb;
          nl = sq[31:0];
          nh = sr[31:0];
        end
      end
      MD_DIVU: begin
        n = DIV_N;
        if (b != 32'd0) begin
          nl = a / b;
          nh = a % b;
        end
      end
`endif
      MD_MTHI: nh = a;
      MD_MTLO: nl = a;
      default: n = 0;
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge where busy is low again.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int          n, cnt;
    logic [31:0] nh, nl, oh, ol;
    model_op(op, a, b, n, nh, nl);
    oh = m_hi;
    ol = m_lo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      check({tag, "_hold_hi"}, bus.hi, oh);
      check({tag, "_hold_lo"}, bus.lo, ol);
      cnt++;
      @(negedge clk);
    end
    m_hi = nh;
    m_lo = nl;
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
    check({tag, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_hi"}, bus.hi, m_hi);
    check({tag, "_lo"}, bus.lo, m_lo);
  endtask

  initial begin
    int          cnt, n;
    logic [31:0] nh, nl, ra, rb;
    logic [2:0]  rop;

    reset     = 1'b0;
    bus.start = 1'b1;
    bus.op    = MD_MTHI;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);
    bus.start = 1'b0;
    reset     = 1'b1;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    @(negedge clk);
    check("post_reset_hi", bus.hi, 32'd0);

    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_neg_hi_lit", bus.hi, 32'hFFFF_FFFF);
    check("mult_neg_lo_lit", bus.lo, 32'hFFFF_FFFA);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu_hi_lit", bus.hi, 32'h0000_0001);
    check("multu_lo_lit", bus.lo, 32'hFFFF_FFFE);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("mthi", MD_MTHI, 32'h11, 32'd0);
    run_op("mtlo", MD_MTLO, 32'h22, 32'd0);
    run_op("divu_zero", MD_DIVU, 32'h1234_5678, 32'd0);
    check("divu_zero_hi_lit", bus.hi, 32'h11);
    check("divu_zero_lo_lit", bus.lo, 32'h22);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_sgn", MD_DIV, 32'd7, 32'hFFFF_FFFE);
    run_op("mtlo_b2b", MD_MTLO, 32'h1234, 32'd0);
    run_op("mult_b2b", MD_MULT, 32'h0001_0003, 32'hFFFF_0002);
    run_op("inv6", 3'd6, 32'hAAAA_5555, 32'd9);
    run_op("inv7", 3'd7, 32'h5555_AAAA, 32'd9);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op("rand", rop, ra, rb);
    end

    // A second start mid-operation must not disturb the in-flight MULT.
    model_op(MD_MULT, 32'h0000_1111, 32'h0000_2222, n, nh, nl);
    bus.start = 1'b1;
    bus.op    = MD_MULT;
    bus.a     = 32'h0000_1111;
    bus.b     = 32'h0000_2222;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == 2) begin
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.a     = 32'hFFFF_0000;
        bus.b     = 32'h0000_7777;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    m_hi = nh;
    m_lo = nl;
    check("busy_start_cycles", 32'(cnt), 32'(n));
    check("busy_start_hi", bus.hi, m_hi);
    check("busy_start_lo", bus.lo, m_lo);

    run_op("pre_abort_hi", MD_MTHI, 32'h0BAD_F00D, 32'd0);
    run_op("pre_abort_lo", MD_MTLO, 32'h0C0F_FEE0, 32'd0);
    bus.start = 1'b1;
    bus.op    = MD_MULT;
    bus.a     = 32'h0000_0007;
    bus.b     = 32'h0000_0009;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      bus.start = (cnt == 2);
      if (cnt == 4) reset = 1'b0;
      @(negedge clk);
      if (reset == 1'b0) break;
    end
    bus.start = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("abort_cycle", 32'(cnt), 32'd4);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_hi", bus.hi, m_hi);
    check("abort_lo", bus.lo, m_lo);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_late_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_late_hi", bus.hi, m_hi);
    check("abort_late_lo", bus.lo, m_lo);

    run_op("after_abort", MD_MULTU, 32'h8000_0001, 32'h8000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
